// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 stream demultiplexer with manual or alternating steering,
// one holding register per output and per-output delivered-beat counters.
module demux1to2_stream #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   y0,
    output logic               y0_valid,
    input  logic               y0_ready,
    output logic [WIDTH-1:0]   y1,
    output logic               y1_valid,
    input  logic               y1_ready,
    output logic [COUNT_W-1:0] cnt0,
    output logic [COUNT_W-1:0] cnt1
);

    logic               rr_q;
    logic               rr_d;
    logic               tgt;
    logic               accept;
    logic               load0;
    logic               load1;
    logic               drain0;
    logic               drain1;
    logic [WIDTH-1:0]   y0_d;
    logic [WIDTH-1:0]   y1_d;
    logic               y0_valid_d;
    logic               y1_valid_d;
    logic [COUNT_W-1:0] cnt0_d;
    logic [COUNT_W-1:0] cnt1_d;

    // Only the currently targeted slot gates the input handshake.
    assign tgt       = mode ? rr_q : sel;
    assign din_ready = tgt ? (!y1_valid || y1_ready) : (!y0_valid || y0_ready);
    assign accept    = din_valid && din_ready;
    assign load0     = accept && !tgt;
    assign load1     = accept && tgt;
    assign drain0    = y0_valid && y0_ready;
    assign drain1    = y1_valid && y1_ready;

    // Next-state: a load wins over a drain on the same slot, keeping it valid.
    always_comb begin
        y0_d       = y0;
        y1_d       = y1;
        y0_valid_d = y0_valid;
        y1_valid_d = y1_valid;
        cnt0_d     = cnt0;
        cnt1_d     = cnt1;
        rr_d       = rr_q;

        if (load0) begin
            y0_d       = din;
            y0_valid_d = 1'b1;
        end else if (drain0) begin
            y0_valid_d = 1'b0;
        end

        if (load1) begin
            y1_d       = din;
            y1_valid_d = 1'b1;
        end else if (drain1) begin
            y1_valid_d = 1'b0;
        end

        if (drain0) cnt0_d = cnt0 + COUNT_W'(1);
        if (drain1) cnt1_d = cnt1 + COUNT_W'(1);
        if (accept && mode) rr_d = !rr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0       <= '0;
            y1       <= '0;
            y0_valid <= 1'b0;
            y1_valid <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
            rr_q     <= 1'b0;
        end else begin
            y0       <= y0_d;
            y1       <= y1_d;
            y0_valid <= y0_valid_d;
            y1_valid <= y1_valid_d;
            cnt0     <= cnt0_d;
            cnt1     <= cnt1_d;
            rr_q     <= rr_d;
        end
    end

endmodule

// File: tb/tb_demux1to2_stream.sv
// Scoreboard bench for demux1to2_stream: expected beats are queued per output
// on acceptance and compared when the output handshake happens.
module tb_demux1to2_stream;

    localparam int unsigned WIDTH   = 1;
    localparam int unsigned COUNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [WIDTH-1:0]   din = '0;
    logic               din_valid = 1'b0;
    logic               din_ready;
    logic               sel = 1'b0;
    logic               mode = 1'b0;
    logic [WIDTH-1:0]   y0;
    logic               y0_valid;
    logic               y0_ready = 1'b1;
    logic [WIDTH-1:0]   y1;
    logic               y1_valid;
    logic               y1_ready = 1'b1;
    logic [COUNT_W-1:0] cnt0;
    logic [COUNT_W-1:0] cnt1;

    demux1to2_stream #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sel(sel), .mode(mode),
        .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
        .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    int unsigned        total = 0;
    int unsigned        bad = 0;
    logic [WIDTH-1:0]   q0[$];
    logic [WIDTH-1:0]   q1[$];
    logic               rr_m = 1'b0;
    logic [COUNT_W-1:0] exp_cnt0 = '0;
    logic [COUNT_W-1:0] exp_cnt1 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check against the model at negedge, update the model, step past posedge.
    task automatic tick();
        logic             tgt;
        logic             exp_rdy;
        logic [WIDTH-1:0] e;
        @(negedge clk);
        tgt     = mode ? rr_m : sel;
        exp_rdy = tgt ? (q1.size() == 0 || y1_ready) : (q0.size() == 0 || y0_ready);
        chk("din_ready", 32'(din_ready), 32'(exp_rdy));
        chk("y0_valid", 32'(y0_valid), 32'(q0.size() != 0));
        chk("y1_valid", 32'(y1_valid), 32'(q1.size() != 0));
        chk("cnt0", 32'(cnt0), 32'(exp_cnt0));
        chk("cnt1", 32'(cnt1), 32'(exp_cnt1));
        if (q0.size() != 0 && y0_ready) begin
            e = q0.pop_front();
            chk("y0_data", 32'(y0), 32'(e));
            exp_cnt0 = exp_cnt0 + COUNT_W'(1);
        end
        if (q1.size() != 0 && y1_ready) begin
            e = q1.pop_front();
            chk("y1_data", 32'(y1), 32'(e));
            exp_cnt1 = exp_cnt1 + COUNT_W'(1);
        end
        if (din_valid && exp_rdy) begin
            if (tgt) q1.push_back(din);
            else     q0.push_back(din);
            if (mode) rr_m = !rr_m;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        rr_m     = 1'b0;
        exp_cnt0 = '0;
        exp_cnt1 = '0;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        mode      = 1'b0;
        sel       = 1'b0;
        y0_ready  = 1'b1;
        y1_ready  = 1'b1;
        rst_n     = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic d, input logic s);
        din       = d;
        sel       = s;
        din_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic [5:0] alt;

        // Reset and idle
        do_reset();
        chk("rst_y0_valid", 32'(y0_valid), 32'd0);
        chk("rst_y0", 32'(y0), 32'd0);
        chk("rst_ready", 32'(din_ready), 32'd1);
        idle(10);

        // Manual routing
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        idle(2);
        chk("man_cnt0", 32'(cnt0), 32'd2);
        chk("man_cnt1", 32'(cnt1), 32'd2);

        // Alternate mode
        do_reset();
        mode = 1'b1;
        alt  = 6'b001101;
        for (int i = 0; i < 6; i++) beat(alt[i], 1'b0);
        idle(2);
        chk("alt_cnt0", 32'(cnt0), 32'd3);
        chk("alt_cnt1", 32'(cnt1), 32'd3);
        beat(1'b1, 1'b1);
        chk("alt_rr0_y0", 32'(y0_valid), 32'd1);
        chk("alt_rr0_y1", 32'(y1_valid), 32'd0);
        idle(2);

        // Backpressure isolation
        do_reset();
        y1_ready = 1'b0;
        beat(1'b1, 1'b1);
        din = 1'b0;
        sel = 1'b1;
        #1;
        chk("bp_stall", 32'(din_ready), 32'd0);
        tick();
        sel = 1'b0;
        #1;
        chk("bp_switch_rdy", 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0;
        chk("bp_y0_valid", 32'(y0_valid), 32'd1);
        chk("bp_y1_hold", 32'(y1_valid), 32'd1);
        chk("bp_y1_data", 32'(y1), 32'd1);
        tick();
        y1_ready = 1'b1;
        idle(2);
        chk("bp_cnt1", 32'(cnt1), 32'd1);

        // Full throughput
        do_reset();
        for (int i = 0; i < 8; i++) beat(1'(i), 1'b0);
        idle(1);
        chk("tp_cnt0", 32'(cnt0), 32'd8);

        // Counter wrap then reset mid-flight
        do_reset();
        for (int i = 0; i < 257; i++) beat(1'($urandom_range(0, 1)), 1'b0);
        idle(1);
        chk("wrap_cnt0", 32'(cnt0), 32'd1);
        y1_ready = 1'b0;
        beat(1'b1, 1'b1);
        din_valid = 1'b0;
        chk("pre_rst_y1_valid", 32'(y1_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_y1_valid", 32'(y1_valid), 32'd0);
        chk("async_y1", 32'(y1), 32'd0);
        chk("async_cnt0", 32'(cnt0), 32'd0);
        chk("async_cnt1", 32'(cnt1), 32'd0);
        do_reset();
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
